// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RESP_IF,
    RESP_LS
  } state_e;

  typedef enum logic {
    GNT_IFU,
    GNT_LSU
  } grant_e;

endpackage

// File: rtl/mem_arbiter_2to1_arb2_rr.sv
// Two-way grant generator: fixed LSU-over-IFU priority or round-robin.
// req_i/gnt_o bit 0 is the IFU, bit 1 the LSU; gnt_o is one-hot or zero.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_en_i,
  input  grant_e     last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      // Under contention round-robin favours whoever did not win last time.
      gnt_o = (rr_en_i && (last_grant_i == GNT_LSU)) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Shares one 1-cycle-latency memory port between the IFU (read-only) and
// the LSU (read/write); one transaction in flight, response is a 1-cycle pulse.
module mem_arbiter_2to1
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RR_EN  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wmask,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata
);

  state_e     state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic       lsu_wr_q, lsu_wr_d;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;

  // Requests are only eligible in IDLE and never while reset is held, so a
  // grant always implies an accept.
  assign arb_req = {lsu_req_valid, ifu_req_valid} & {2{(state_q == IDLE) && !reset}};

  arb2_rr u_arb (
    .req_i        (arb_req),
    .rr_en_i      (RR_EN != 0),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    lsu_wr_d       = lsu_wr_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    mem_ren        = 1'b0;
    mem_raddr      = '0;
    mem_wen        = 1'b0;
    mem_waddr      = '0;
    mem_wmask      = '0;
    mem_wdata      = '0;
    unique case (state_q)
      IDLE: begin
        ifu_req_ready = arb_gnt[0];
        lsu_req_ready = arb_gnt[1];
        if (arb_gnt[0]) begin
          mem_ren      = 1'b1;
          mem_raddr    = ifu_req_addr;
          state_d      = RESP_IF;
          last_grant_d = GNT_IFU;
        end else if (arb_gnt[1]) begin
          if (lsu_req_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = lsu_req_addr;
            mem_wmask = lsu_req_wmask;
            mem_wdata = lsu_req_wdata;
          end else begin
            mem_ren   = 1'b1;
            mem_raddr = lsu_req_addr;
          end
          lsu_wr_d     = lsu_req_wen;
          state_d      = RESP_LS;
          last_grant_d = GNT_LSU;
        end
      end
      RESP_IF: begin
        ifu_resp_valid = 1'b1;
        ifu_resp_data  = mem_rdata;
        state_d        = IDLE;
      end
      RESP_LS: begin
        lsu_resp_valid = 1'b1;
        lsu_resp_data  = lsu_wr_q ? '0 : mem_rdata;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_LSU;
      lsu_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lsu_wr_q     <= lsu_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed and random checks of mem_arbiter_2to1 in fixed-priority (a) and
// round-robin (b) configurations, each with its own 64-word RAM model.
module tb_mem_arbiter_2to1;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wmask;
  logic [31:0] lsu_req_wdata;

  logic        ifu_req_ready_a, ifu_resp_valid_a, lsu_req_ready_a, lsu_resp_valid_a;
  logic [31:0] ifu_resp_data_a, lsu_resp_data_a;
  logic        mem_ren_a, mem_wen_a;
  logic [31:0] mem_raddr_a, mem_rdata_a, mem_waddr_a, mem_wmask_a, mem_wdata_a;
  logic        ifu_req_ready_b, ifu_resp_valid_b, lsu_req_ready_b, lsu_resp_valid_b;
  logic [31:0] ifu_resp_data_b, lsu_resp_data_b;
  logic        mem_ren_b, mem_wen_b;
  logic [31:0] mem_raddr_b, mem_rdata_b, mem_waddr_b, mem_wmask_b, mem_wdata_b;

  logic [31:0] ram_a [64];
  logic [31:0] ram_b [64];
  logic [31:0] ref_mem [64];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_a (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_a), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid_a), .ifu_resp_data(ifu_resp_data_a),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_a), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wmask(lsu_req_wmask), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_valid(lsu_resp_valid_a), .lsu_resp_data(lsu_resp_data_a),
    .mem_ren(mem_ren_a), .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a),
    .mem_wen(mem_wen_a), .mem_waddr(mem_waddr_a), .mem_wmask(mem_wmask_a), .mem_wdata(mem_wdata_a)
  );

  mem_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut_b (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_b), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid_b), .ifu_resp_data(ifu_resp_data_b),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_b), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wmask(lsu_req_wmask), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_valid(lsu_resp_valid_b), .lsu_resp_data(lsu_resp_data_b),
    .mem_ren(mem_ren_b), .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b),
    .mem_wen(mem_wen_b), .mem_waddr(mem_waddr_b), .mem_wmask(mem_wmask_b), .mem_wdata(mem_wdata_b)
  );

  // Word index: addr[13:12] selects a region, addr[5:2] the word within it.
  function automatic logic [5:0] ridx(input logic [31:0] a);
    return {a[13:12], a[5:2]};
  endfunction

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 0) ? 32'h0000_0413 : (32'hA5A5_0000 | i);
  endfunction

  // RAMs reload their initial image while reset is held.
  always @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 64; i++) begin
        ram_a[i[5:0]] <= init_word(i);
        ram_b[i[5:0]] <= init_word(i);
      end
      mem_rdata_a <= '0;
      mem_rdata_b <= '0;
    end else begin
      if (mem_wen_a)
        ram_a[ridx(mem_waddr_a)] <= (ram_a[ridx(mem_waddr_a)] & ~mem_wmask_a) | (mem_wdata_a & mem_wmask_a);
      if (mem_ren_a) mem_rdata_a <= ram_a[ridx(mem_raddr_a)];
      if (mem_wen_b)
        ram_b[ridx(mem_waddr_b)] <= (ram_b[ridx(mem_waddr_b)] & ~mem_wmask_b) | (mem_wdata_b & mem_wmask_b);
      if (mem_ren_b) mem_rdata_b <= ram_b[ridx(mem_raddr_b)];
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    tests++; if (ifu_req_ready_a !== 1'b0) begin fails++; $display("FAIL rst_ifu_ready got %b exp 0", ifu_req_ready_a); end
    tests++; if (lsu_req_ready_b !== 1'b0) begin fails++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_req_ready_b); end
    tests++; if ({ifu_resp_valid_a, lsu_resp_valid_a, ifu_resp_valid_b, lsu_resp_valid_b} !== 4'b0) begin
      fails++; $display("FAIL rst_resp_valid got %b%b%b%b exp 0000", ifu_resp_valid_a, lsu_resp_valid_a, ifu_resp_valid_b, lsu_resp_valid_b); end
    tests++; if ({mem_ren_a, mem_wen_a, mem_ren_b, mem_wen_b} !== 4'b0) begin
      fails++; $display("FAIL rst_mem_en got %b%b%b%b exp 0000", mem_ren_a, mem_wen_a, mem_ren_b, mem_wen_b); end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++; if ({mem_ren_a, mem_wen_a, ifu_req_ready_a, lsu_req_ready_a} !== 4'b0) begin
      fails++; $display("FAIL idle_no_req got %b%b%b%b exp 0000", mem_ren_a, mem_wen_a, ifu_req_ready_a, lsu_req_ready_a); end
  endtask

  task automatic test_ifu_read();
    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    tests++; if (ifu_req_ready_a !== 1'b1) begin fails++; $display("FAIL ifu_ready got %b exp 1", ifu_req_ready_a); end
    tests++; if (mem_ren_a !== 1'b1 || mem_wen_a !== 1'b0) begin fails++; $display("FAIL ifu_mem_en got ren=%b wen=%b exp ren=1 wen=0", mem_ren_a, mem_wen_a); end
    tests++; if (mem_raddr_a !== 32'h8000_0000) begin fails++; $display("FAIL ifu_raddr got %h exp 80000000", mem_raddr_a); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    #1;
    tests++; if (ifu_resp_valid_a !== 1'b1) begin fails++; $display("FAIL ifu_resp_valid got %b exp 1", ifu_resp_valid_a); end
    tests++; if (ifu_resp_data_a !== 32'h0000_0413) begin fails++; $display("FAIL ifu_resp_data got %h exp 00000413", ifu_resp_data_a); end
    tests++; if (lsu_resp_valid_a !== 1'b0 || mem_ren_a !== 1'b0) begin fails++; $display("FAIL ifu_resp_side got lsu_v=%b ren=%b exp 0 0", lsu_resp_valid_a, mem_ren_a); end
    @(negedge clock);
    ifu_req_valid = 1'b1;
    #1;
    tests++; if (ifu_resp_valid_a !== 1'b0 || ifu_resp_data_a !== 32'h0) begin fails++; $display("FAIL ifu_pulse_end got v=%b d=%h exp 0 0", ifu_resp_valid_a, ifu_resp_data_a); end
    tests++; if (ifu_req_ready_a !== 1'b1) begin fails++; $display("FAIL ifu_idle_again got %b exp 1", ifu_req_ready_a); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    #1;
    tests++; if (ifu_resp_data_a !== 32'h0000_0413) begin fails++; $display("FAIL ifu_resp_data2 got %h exp 00000413", ifu_resp_data_a); end
  endtask

  task automatic test_write_read();
    @(negedge clock);
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b1;
    lsu_req_addr  = 32'h8000_1000;
    lsu_req_wmask = 32'h0000_FFFF;
    lsu_req_wdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (lsu_req_ready_a !== 1'b1) begin fails++; $display("FAIL wr_ready got %b exp 1", lsu_req_ready_a); end
    tests++; if (mem_wen_a !== 1'b1 || mem_ren_a !== 1'b0) begin fails++; $display("FAIL wr_mem_en got wen=%b ren=%b exp wen=1 ren=0", mem_wen_a, mem_ren_a); end
    tests++; if ({mem_waddr_a, mem_wmask_a, mem_wdata_a} !== {32'h8000_1000, 32'h0000_FFFF, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL wr_fields got %h/%h/%h exp 80001000/0000ffff/deadbeef", mem_waddr_a, mem_wmask_a, mem_wdata_a); end
    @(negedge clock);
    lsu_req_valid = 1'b0;
    lsu_req_wdata = 32'h1234_5678;
    #1;
    tests++; if (lsu_resp_valid_a !== 1'b1 || lsu_resp_data_a !== 32'h0) begin fails++; $display("FAIL wr_resp got v=%b d=%h exp 1 0", lsu_resp_valid_a, lsu_resp_data_a); end
    tests++; if (mem_wen_a !== 1'b0) begin fails++; $display("FAIL wr_single_pulse got %b exp 0", mem_wen_a); end
    @(negedge clock);
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    #1;
    tests++; if (mem_ren_a !== 1'b1 || mem_raddr_a !== 32'h8000_1000) begin fails++; $display("FAIL rd_mem got ren=%b a=%h exp 1 80001000", mem_ren_a, mem_raddr_a); end
    @(negedge clock);
    lsu_req_valid = 1'b0;
    #1;
    tests++; if (lsu_resp_valid_a !== 1'b1) begin fails++; $display("FAIL rd_resp_valid got %b exp 1", lsu_resp_valid_a); end
    tests++; if (lsu_resp_data_a !== 32'hA5A5_BEEF) begin fails++; $display("FAIL rd_merged got %h exp a5a5beef", lsu_resp_data_a); end
    tests++; if (lsu_resp_data_b !== 32'hA5A5_BEEF) begin fails++; $display("FAIL rd_merged_rr got %h exp a5a5beef", lsu_resp_data_b); end
  endtask

  task automatic test_contention();
    logic exp_ifu;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 32'h8000_2000;
    for (int k = 0; k < 4; k++) begin
      exp_ifu = (k % 2 == 0);
      #1;
      tests++; if (lsu_req_ready_a !== 1'b1 || ifu_req_ready_a !== 1'b0) begin
        fails++; $display("FAIL fix_grant%0d got ifu=%b lsu=%b exp 0 1", k, ifu_req_ready_a, lsu_req_ready_a); end
      tests++; if (mem_raddr_a !== 32'h8000_2000) begin fails++; $display("FAIL fix_raddr%0d got %h exp 80002000", k, mem_raddr_a); end
      tests++; if (ifu_req_ready_b !== exp_ifu || lsu_req_ready_b !== !exp_ifu) begin
        fails++; $display("FAIL rr_grant%0d got ifu=%b lsu=%b exp ifu=%b", k, ifu_req_ready_b, lsu_req_ready_b, exp_ifu); end
      tests++; if (mem_raddr_b !== (exp_ifu ? 32'h8000_0000 : 32'h8000_2000)) begin
        fails++; $display("FAIL rr_raddr%0d got %h exp %h", k, mem_raddr_b, exp_ifu ? 32'h8000_0000 : 32'h8000_2000); end
      @(negedge clock);
      #1;
      tests++; if (lsu_resp_valid_a !== 1'b1 || ifu_resp_valid_a !== 1'b0 || lsu_resp_data_a !== 32'hA5A5_0020) begin
        fails++; $display("FAIL fix_resp%0d got lv=%b iv=%b d=%h exp 1 0 a5a50020", k, lsu_resp_valid_a, ifu_resp_valid_a, lsu_resp_data_a); end
      tests++; if (ifu_req_ready_a !== 1'b0) begin fails++; $display("FAIL fix_stall%0d got %b exp 0", k, ifu_req_ready_a); end
      tests++; if (ifu_resp_valid_b !== exp_ifu || lsu_resp_valid_b !== !exp_ifu) begin
        fails++; $display("FAIL rr_resp_side%0d got iv=%b lv=%b exp iv=%b", k, ifu_resp_valid_b, lsu_resp_valid_b, exp_ifu); end
      tests++; if ((exp_ifu ? ifu_resp_data_b : lsu_resp_data_b) !== (exp_ifu ? 32'h0000_0413 : 32'hA5A5_0020)) begin
        fails++; $display("FAIL rr_resp_data%0d got %h exp %h", k, exp_ifu ? ifu_resp_data_b : lsu_resp_data_b, exp_ifu ? 32'h0000_0413 : 32'hA5A5_0020); end
      @(negedge clock);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
  endtask

  task automatic test_late_lsu();
    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    tests++; if (ifu_req_ready_a !== 1'b1) begin fails++; $display("FAIL late_ifu_ready got %b exp 1", ifu_req_ready_a); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 32'h8000_2000;
    #1;
    tests++; if (lsu_req_ready_a !== 1'b0 || mem_ren_a !== 1'b0) begin fails++; $display("FAIL late_blocked got rdy=%b ren=%b exp 0 0", lsu_req_ready_a, mem_ren_a); end
    tests++; if (ifu_resp_valid_a !== 1'b1) begin fails++; $display("FAIL late_ifu_resp got %b exp 1", ifu_resp_valid_a); end
    @(negedge clock);
    #1;
    tests++; if (lsu_req_ready_a !== 1'b1 || mem_ren_a !== 1'b1 || mem_raddr_a !== 32'h8000_2000) begin
      fails++; $display("FAIL late_accept got rdy=%b ren=%b a=%h exp 1 1 80002000", lsu_req_ready_a, mem_ren_a, mem_raddr_a); end
    @(negedge clock);
    lsu_req_valid = 1'b0;
    #1;
    tests++; if (lsu_resp_valid_a !== 1'b1 || lsu_resp_data_a !== 32'hA5A5_0020) begin
      fails++; $display("FAIL late_resp got v=%b d=%h exp 1 a5a50020", lsu_resp_valid_a, lsu_resp_data_a); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    tests++; if (ifu_req_ready_a !== 1'b1) begin fails++; $display("FAIL mid_ready got %b exp 1", ifu_req_ready_a); end
    @(posedge clock);
    #1;
    ifu_req_valid = 1'b0;
    tests++; if (ifu_resp_valid_a !== 1'b1) begin fails++; $display("FAIL mid_pre_resp got %b exp 1", ifu_resp_valid_a); end
    #1;
    reset = 1'b1;
    #1;
    tests++; if ({ifu_resp_valid_a, lsu_resp_valid_a, ifu_req_ready_a, mem_ren_a, mem_wen_a} !== 5'b0) begin
      fails++; $display("FAIL mid_abort got %b%b%b%b%b exp 00000", ifu_resp_valid_a, lsu_resp_valid_a, ifu_req_ready_a, mem_ren_a, mem_wen_a); end
    tests++; if (ifu_resp_data_a !== 32'h0) begin fails++; $display("FAIL mid_abort_data got %h exp 0", ifu_resp_data_a); end
    @(negedge clock);
    #1;
    tests++; if (ifu_resp_valid_a !== 1'b0) begin fails++; $display("FAIL mid_no_resp got %b exp 0", ifu_resp_valid_a); end
    @(negedge clock);
    reset = 1'b0;
    ifu_req_valid = 1'b1;
    #1;
    tests++; if (ifu_req_ready_a !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b exp 1", ifu_req_ready_a); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    #1;
    tests++; if (ifu_resp_valid_a !== 1'b1 || ifu_resp_data_a !== 32'h0000_0413) begin
      fails++; $display("FAIL post_rst_resp got v=%b d=%h exp 1 00000413", ifu_resp_valid_a, ifu_resp_data_a); end
  endtask

  task automatic test_random();
    logic        ifu_acc, lsu_acc, exp_if, exp_ls;
    logic [31:0] exp_if_d, exp_ls_d;
    for (int unsigned i = 0; i < 64; i++) ref_mem[i[5:0]] = init_word(i);
    ifu_acc = 1'b0; lsu_acc = 1'b0; exp_if = 1'b0; exp_ls = 1'b0;
    exp_if_d = '0; exp_ls_d = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      if (!ifu_req_valid || ifu_acc) begin
        ifu_req_valid = 1'($urandom_range(0, 1));
        ifu_req_addr  = 32'h1000_3000 | (32'($urandom_range(0, 15)) << 2);
      end
      if (!lsu_req_valid || lsu_acc) begin
        lsu_req_valid = 1'($urandom_range(0, 1));
        lsu_req_wen   = 1'($urandom_range(0, 1));
        lsu_req_addr  = 32'h1000_3000 | (32'($urandom_range(0, 15)) << 2);
        lsu_req_wmask = $urandom;
        lsu_req_wdata = $urandom;
      end
      #1;
      tests++; if (mem_ren_b && mem_wen_b) begin fails++; $display("FAIL rnd_overlap_rr cyc %0d got ren=1 wen=1 exp exclusive", c); end
      tests++; if (mem_ren_a && mem_wen_a) begin fails++; $display("FAIL rnd_overlap_fix cyc %0d got ren=1 wen=1 exp exclusive", c); end
      tests++; if (ifu_resp_valid_b !== exp_if) begin fails++; $display("FAIL rnd_ifu_resp cyc %0d got %b exp %b", c, ifu_resp_valid_b, exp_if); end
      if (exp_if) begin
        tests++; if (ifu_resp_data_b !== exp_if_d) begin fails++; $display("FAIL rnd_ifu_data cyc %0d got %h exp %h", c, ifu_resp_data_b, exp_if_d); end
      end
      tests++; if (lsu_resp_valid_b !== exp_ls) begin fails++; $display("FAIL rnd_lsu_resp cyc %0d got %b exp %b", c, lsu_resp_valid_b, exp_ls); end
      if (exp_ls) begin
        tests++; if (lsu_resp_data_b !== exp_ls_d) begin fails++; $display("FAIL rnd_lsu_data cyc %0d got %h exp %h", c, lsu_resp_data_b, exp_ls_d); end
      end
      ifu_acc = ifu_req_valid && ifu_req_ready_b;
      lsu_acc = lsu_req_valid && lsu_req_ready_b;
      exp_if  = ifu_acc;
      exp_ls  = lsu_acc;
      if (ifu_acc) begin
        exp_if_d = ref_mem[ridx(ifu_req_addr)];
        tests++; if (mem_raddr_b !== ifu_req_addr) begin fails++; $display("FAIL rnd_ifu_raddr cyc %0d got %h exp %h", c, mem_raddr_b, ifu_req_addr); end
      end
      if (lsu_acc && lsu_req_wen) begin
        exp_ls_d = '0;
        ref_mem[ridx(lsu_req_addr)] = (ref_mem[ridx(lsu_req_addr)] & ~lsu_req_wmask) | (lsu_req_wdata & lsu_req_wmask);
        tests++; if (mem_waddr_b !== lsu_req_addr) begin fails++; $display("FAIL rnd_waddr cyc %0d got %h exp %h", c, mem_waddr_b, lsu_req_addr); end
      end else if (lsu_acc) begin
        exp_ls_d = ref_mem[ridx(lsu_req_addr)];
        tests++; if (mem_raddr_b !== lsu_req_addr) begin fails++; $display("FAIL rnd_lsu_raddr cyc %0d got %h exp %h", c, mem_raddr_b, lsu_req_addr); end
      end
    end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    tests++; if (ifu_resp_valid_b !== exp_if || lsu_resp_valid_b !== exp_ls) begin
      fails++; $display("FAIL rnd_last_resp got iv=%b lv=%b exp %b %b", ifu_resp_valid_b, lsu_resp_valid_b, exp_if, exp_ls); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wmask = '0;
    lsu_req_wdata = '0;
    test_reset();
    test_ifu_read();
    test_write_read();
    test_contention();
    test_late_lsu();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
